// File: rtl/susys_pkg.sv
// Shared widths, opcode/state enums and the mailbox slot record for server_user_proc.
package susys_pkg;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int IDW   = 7;
  localparam int SLOTS = 2 ** AW;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_INC  = 2'd1,
    OP_INV  = 2'd2,
    OP_SWAP = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } slot_t;

endpackage

// File: rtl/susys_opu.sv
// Combinational operation unit: pass, increment, invert or nibble-swap one data word.
module susys_opu
  import susys_pkg::*;
(
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_result
);

  always_comb begin
    o_result = i_data;
    unique case (op_e'(i_op))
      OP_PASS: o_result = i_data;
      OP_INC:  o_result = i_data + DW'(1);
      OP_INV:  o_result = ~i_data;
      OP_SWAP: o_result = {i_data[DW/2-1:0], i_data[DW-1:DW/2]};
    endcase
  end

endmodule

// File: rtl/server_user_proc.sv
// 16-slot tagged mailbox served round-robin through the OPU, one result per two cycles.
// Optional SUSYS_STATS_EN adds done_count (wrapping) and ovw_count (saturating) outputs.
module server_user_proc
  import susys_pkg::*;
(
  input  logic           s_clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  data_in,
  input  logic [IDW-1:0] ID,
  output logic           result_valid,
  output logic [DW-1:0]  result_data,
  output logic [IDW-1:0] result_id,
  output logic [AW-1:0]  result_addr,
  output logic           overwrite,
  output logic           busy
`ifdef SUSYS_STATS_EN
  ,
  output logic [15:0]    done_count,
  output logic [7:0]     ovw_count
`endif
);

  slot_t          r_slots [SLOTS];
  logic [AW-1:0]  r_ptr;
  state_e         r_state;
  state_e         w_state_nxt;

  logic [IDW-1:0] r_id_p0;
  logic [DW-1:0]  r_data_p0;
  logic [AW-1:0]  r_idx_p0;

  logic           r_vld_p1;
  logic [DW-1:0]  r_data_p1;
  logic [IDW-1:0] r_id_p1;
  logic [AW-1:0]  r_idx_p1;
  logic           r_ovw;

  logic           w_found;
  logic [AW-1:0]  w_sel;
  logic           w_pick;
  logic           w_clr;
  logic           w_ovw;
  logic [DW-1:0]  w_opu;

  // First valid slot at or after the pointer, wrapping past the top slot.
  always_comb begin
    logic [AW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      v_idx = r_ptr + AW'(i);
      if (!w_found && r_slots[v_idx].valid) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_found) w_state_nxt = EXEC;
      EXEC: w_state_nxt = IDLE;
    endcase
  end

  assign w_pick = (r_state == IDLE) && w_found;
  assign w_clr  = (r_state == EXEC);
  // A load landing on the slot being retired this edge is not an overwrite.
  assign w_ovw  = load && r_slots[addr].valid && !(w_clr && (addr == r_idx_p0));

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) r_slots[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (load && (addr == AW'(i))) begin
          r_slots[i] <= '{valid: 1'b1, id: ID, data: data_in};
        end else if (w_clr && (r_idx_p0 == AW'(i))) begin
          r_slots[i].valid <= 1'b0;
        end
      end
    end
  end

  // Stage p0: latch the selected slot in IDLE
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_p0   <= '0;
      r_data_p0 <= '0;
      r_idx_p0  <= '0;
    end else if (w_pick) begin
      r_id_p0   <= r_slots[w_sel].id;
      r_data_p0 <= r_slots[w_sel].data;
      r_idx_p0  <= w_sel;
    end
  end

  susys_opu u_opu (
    .i_op     (r_id_p0[1:0]),
    .i_data   (r_data_p0),
    .o_result (w_opu)
  );

  // Stage p1: register the OPU result in EXEC and advance the pointer
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_id_p1   <= '0;
      r_idx_p1  <= '0;
      r_ptr     <= '0;
      r_ovw     <= 1'b0;
    end else begin
      r_vld_p1 <= w_clr;
      r_ovw    <= w_ovw;
      if (w_clr) begin
        r_data_p1 <= w_opu;
        r_id_p1   <= r_id_p0;
        r_idx_p1  <= r_idx_p0;
        r_ptr     <= r_idx_p0 + AW'(1);
      end
    end
  end

  assign result_valid = r_vld_p1;
  assign result_data  = r_data_p1;
  assign result_id    = r_id_p1;
  assign result_addr  = r_idx_p1;
  assign overwrite    = r_ovw;
  assign busy         = (r_state == EXEC);

`ifdef SUSYS_STATS_EN
  logic [15:0] r_done_cnt;
  logic [7:0]  r_ovw_cnt;

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
      r_ovw_cnt  <= '0;
    end else begin
      if (w_clr) r_done_cnt <= r_done_cnt + 16'd1;
      if (w_ovw && (r_ovw_cnt != 8'hFF)) r_ovw_cnt <= r_ovw_cnt + 8'd1;
    end
  end

  assign done_count = r_done_cnt;
  assign ovw_count  = r_ovw_cnt;
`endif

endmodule

// File: tb/tb_server_user_proc.sv
// Directed bench for server_user_proc with a result scoreboard; define SUSYS_STATS_EN to also check counters.
module tb_server_user_proc;

  logic       s_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [6:0] ID = '0;
  logic       result_valid;
  logic [7:0] result_data;
  logic [6:0] result_id;
  logic [3:0] result_addr;
  logic       overwrite;
  logic       busy;
`ifdef SUSYS_STATS_EN
  logic [15:0] done_count;
  logic [7:0]  ovw_count;
`endif

  server_user_proc dut (
    .s_clk        (s_clk),
    .rst_n        (rst_n),
    .load         (load),
    .addr         (addr),
    .data_in      (data_in),
    .ID           (ID),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_id    (result_id),
    .result_addr  (result_addr),
    .overwrite    (overwrite),
    .busy         (busy)
`ifdef SUSYS_STATS_EN
    ,
    .done_count   (done_count),
    .ovw_count    (ovw_count)
`endif
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    logic [3:0] a;
    logic [6:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_res = 0;
  int   n_ovw = 0;
  int   last_cyc = 0;
  int   prev_cyc = 0;
  int   lat_edge = 0;
  bit   lat_arm = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [3:0] a, input logic [6:0] id, input logic [7:0] d);
    @(negedge s_clk);
    load = l; addr = a; ID = id; data_in = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 7'd0, 8'd0);
  endtask

  task automatic expect_res(input logic [3:0] a, input logic [6:0] id, input logic [7:0] d);
    exp_t e;
    e.a = a; e.id = id; e.d = d;
    sb.push_back(e);
  endtask

  always @(posedge s_clk) cyc <= cyc + 1;

  always @(negedge s_clk) begin
    if (rst_n && result_valid) begin
      n_res++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      chk("result_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result_addr", 32'(result_addr), 32'(e.a));
        chk("result_id", 32'(result_id), 32'(e.id));
        chk("result_data", 32'(result_data), 32'(e.d));
      end
      if (lat_arm) begin
        chk("first_latency", 32'(cyc - lat_edge), 32'd2);
        lat_arm = 1'b0;
      end
    end
    if (rst_n && overwrite) n_ovw++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    #20;
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_data", 32'(result_data), 32'd0);
    chk("rst_result_id", 32'(result_id), 32'd0);
    chk("rst_result_addr", 32'(result_addr), 32'd0);
    chk("rst_overwrite", 32'(overwrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef SUSYS_STATS_EN
    chk("rst_done_count", 32'(done_count), 32'd0);
    chk("rst_ovw_count", 32'(ovw_count), 32'd0);
`endif
    #30 rst_n = 1'b1;
    idle(20);
    chk("idle_no_results", 32'(n_res), 32'd0);

    // Three consecutive loads, one per opcode flavour
    expect_res(4'd2, 7'b1010001, 8'h12);
    expect_res(4'd4, 7'b1110010, 8'hDD);
    expect_res(4'd9, 7'b1010100, 8'h33);
    drive(1'b1, 4'd2, 7'b1010001, 8'h11);
    lat_edge = cyc + 1;
    lat_arm  = 1'b1;
    drive(1'b1, 4'd4, 7'b1110010, 8'h22);
    drive(1'b1, 4'd9, 7'b1010100, 8'h33);
    idle(12);
    chk("basic_results", 32'(n_res), 32'd3);

    // Wrap: slot 14 served, then 3 and 15 pending -> 15 first
    expect_res(4'd14, 7'b0001100, 8'h44);
    expect_res(4'd15, 7'b0010111, 8'h21);
    expect_res(4'd3,  7'b0000110, 8'hF0);
    drive(1'b1, 4'd14, 7'b0001100, 8'h44);
    drive(1'b1, 4'd3,  7'b0000110, 8'h0F);
    drive(1'b1, 4'd15, 7'b0010111, 8'h12);
    idle(10);
    expect_res(4'd0, 7'b1111101, 8'h00);
    drive(1'b1, 4'd0, 7'b1111101, 8'hFF);
    idle(8);
    chk("wrap_results", 32'(n_res), 32'd7);
    chk("no_overwrite_yet", 32'(n_ovw), 32'd0);

    // Overwrite slot 5 while slot 10 is in service
    expect_res(4'd10, 7'b0000000, 8'h77);
    expect_res(4'd5,  7'b0100010, 8'h99);
    drive(1'b1, 4'd10, 7'b0000000, 8'h77);
    drive(1'b1, 4'd5,  7'b0000001, 8'h55);
    drive(1'b1, 4'd5,  7'b0100010, 8'h66);
    idle(10);
    chk("overwrite_pulses", 32'(n_ovw), 32'd1);
    chk("overwrite_results", 32'(n_res), 32'd9);
`ifdef SUSYS_STATS_EN
    chk("ovw_count", 32'(ovw_count), 32'd1);
`endif

    // Collision: reload slot 7 on its own EXEC edge
    expect_res(4'd7, 7'b0000011, 8'h5A);
    expect_res(4'd7, 7'b0000011, 8'hC3);
    drive(1'b1, 4'd7, 7'b0000011, 8'hA5);
    idle(1);
    drive(1'b1, 4'd7, 7'b0000011, 8'h3C);
    idle(10);
    chk("collision_results", 32'(n_res), 32'd11);
    chk("collision_spacing", 32'(last_cyc - prev_cyc), 32'd2);
    chk("collision_no_ovw", 32'(n_ovw), 32'd1);
`ifdef SUSYS_STATS_EN
    chk("done_count", 32'(done_count), 32'd11);
`endif

    // Reset while slot 11 is in EXEC and slot 12 pending
    drive(1'b1, 4'd11, 7'b0000001, 8'hAA);
    drive(1'b1, 4'd12, 7'b0000010, 8'hBB);
    @(negedge s_clk);
    load = 1'b0;
    chk("busy_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_in_reset", 32'(busy), 32'd0);
    chk("valid_in_reset", 32'(result_valid), 32'd0);
    repeat (3) @(negedge s_clk);
    rst_n = 1'b1;
    idle(30);
    chk("no_results_after_reset", 32'(n_res), 32'd11);
`ifdef SUSYS_STATS_EN
    chk("done_count_after_reset", 32'(done_count), 32'd0);
`endif
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
